// File: rtl/axi_lite_banked_memory.sv
// AXI4-Lite slave scratchpad memory: byte strobes, AW/W captured independently, one read per cycle.
// Optional macro AXIL_MEM_ADDR_CHECK_EN: word indices >= DEPTH answer DECERR instead of aliasing.
module axi_lite_banked_memory #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ADDR_W-1:0]   S_AXIL_AWADDR,
  input  logic                S_AXIL_AWVALID,
  output logic                S_AXIL_AWREADY,
  input  logic [DATA_W-1:0]   S_AXIL_WDATA,
  input  logic [DATA_W/8-1:0] S_AXIL_WSTRB,
  input  logic                S_AXIL_WVALID,
  output logic                S_AXIL_WREADY,
  output logic [1:0]          S_AXIL_BRESP,
  output logic                S_AXIL_BVALID,
  input  logic                S_AXIL_BREADY,
  input  logic [ADDR_W-1:0]   S_AXIL_ARADDR,
  input  logic                S_AXIL_ARVALID,
  output logic                S_AXIL_ARREADY,
  output logic [DATA_W-1:0]   S_AXIL_RDATA,
  output logic [1:0]          S_AXIL_RRESP,
  output logic                S_AXIL_RVALID,
  input  logic                S_AXIL_RREADY
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic              aw_full, w_full, aw_full_d, w_full_d;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [STRB_W-1:0] w_strb_q;
  logic              aw_hs, w_hs, ar_hs, commit, mem_we;
  logic [ADDR_W-1:0] aw_word, ar_word;
  logic              aw_hit, ar_hit;
  logic [1:0]        aw_resp, ar_resp;
  logic [IDX_W-1:0]  aw_idx, ar_idx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              unused_addr_bits;

  assign aw_hs  = S_AXIL_AWVALID && S_AXIL_AWREADY;
  assign w_hs   = S_AXIL_WVALID && S_AXIL_WREADY;
  assign ar_hs  = S_AXIL_ARVALID && S_AXIL_ARREADY;
  assign commit = aw_full && w_full && !S_AXIL_BVALID;
  assign mem_we = commit && aw_hit && !ARESET;
  assign S_AXIL_ARREADY = !ARESET && (!S_AXIL_RVALID || S_AXIL_RREADY);

  // Only the bits that select a word matter; byte offsets and aliased upper bits are dropped.
  assign unused_addr_bits = ^{aw_addr_q, S_AXIL_ARADDR};

`ifdef AXIL_MEM_ADDR_CHECK_EN
  assign aw_word = aw_addr_q >> OFF_W;
  assign ar_word = S_AXIL_ARADDR >> OFF_W;
  assign aw_resp = aw_hit ? RESP_OKAY : RESP_DECERR;
  assign ar_resp = ar_hit ? RESP_OKAY : RESP_DECERR;
`else
  assign aw_word = ADDR_W'(aw_addr_q[OFF_W +: IDX_W]);
  assign ar_word = ADDR_W'(S_AXIL_ARADDR[OFF_W +: IDX_W]);
  assign aw_resp = RESP_OKAY;
  assign ar_resp = RESP_OKAY;
`endif

  assign aw_hit = aw_word < ADDR_W'(DEPTH);
  assign ar_hit = ar_word < ADDR_W'(DEPTH);
  assign aw_idx = aw_word[IDX_W-1:0];
  assign ar_idx = ar_word[IDX_W-1:0];

  always_comb begin
    aw_full_d = aw_full;
    w_full_d  = w_full;
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
    end else begin
      if (aw_hs) aw_full_d = 1'b1;
      if (w_hs)  w_full_d  = 1'b1;
    end
  end

  // Ready flags are registered copies of the next-state holding flags so they never follow VALID.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_full        <= 1'b0;
      w_full         <= 1'b0;
      S_AXIL_AWREADY <= 1'b0;
      S_AXIL_WREADY  <= 1'b0;
      S_AXIL_BVALID  <= 1'b0;
      S_AXIL_BRESP   <= RESP_OKAY;
      aw_addr_q      <= '0;
      w_data_q       <= '0;
      w_strb_q       <= '0;
    end else begin
      aw_full        <= aw_full_d;
      w_full         <= w_full_d;
      S_AXIL_AWREADY <= !aw_full_d;
      S_AXIL_WREADY  <= !w_full_d;
      if (aw_hs) aw_addr_q <= S_AXIL_AWADDR;
      if (w_hs) begin
        w_data_q <= S_AXIL_WDATA;
        w_strb_q <= S_AXIL_WSTRB;
      end
      if (commit) begin
        S_AXIL_BVALID <= 1'b1;
        S_AXIL_BRESP  <= aw_resp;
      end else if (S_AXIL_BVALID && S_AXIL_BREADY) begin
        S_AXIL_BVALID <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (w_strb_q[i]) mem[aw_idx][8*i +: 8] <= w_data_q[8*i +: 8];
      end
    end
  end

  // Array reads use the pre-edge contents, so a same-cycle commit is not visible to this read.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      S_AXIL_RVALID <= 1'b0;
      S_AXIL_RDATA  <= '0;
      S_AXIL_RRESP  <= RESP_OKAY;
    end else if (ar_hs) begin
      S_AXIL_RVALID <= 1'b1;
      S_AXIL_RDATA  <= ar_hit ? mem[ar_idx] : '0;
      S_AXIL_RRESP  <= ar_resp;
    end else if (S_AXIL_RREADY) begin
      S_AXIL_RVALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_lite_banked_memory.sv
// Self-checking bench for axi_lite_banked_memory (DATA_W=32, DEPTH=200) against a word-array model.
// Expected responses follow AXIL_MEM_ADDR_CHECK_EN when it is defined for the build.
module tb_axi_lite_banked_memory;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 200;
  localparam int SLOTS  = 256;

  logic              ACLK = 1'b0;
  logic              ARESET = 1'b1;
  logic [ADDR_W-1:0] S_AXIL_AWADDR = '0;
  logic              S_AXIL_AWVALID = 1'b0;
  logic              S_AXIL_AWREADY;
  logic [DATA_W-1:0] S_AXIL_WDATA = '0;
  logic [3:0]        S_AXIL_WSTRB = '0;
  logic              S_AXIL_WVALID = 1'b0;
  logic              S_AXIL_WREADY;
  logic [1:0]        S_AXIL_BRESP;
  logic              S_AXIL_BVALID;
  logic              S_AXIL_BREADY = 1'b0;
  logic [ADDR_W-1:0] S_AXIL_ARADDR = '0;
  logic              S_AXIL_ARVALID = 1'b0;
  logic              S_AXIL_ARREADY;
  logic [DATA_W-1:0] S_AXIL_RDATA;
  logic [1:0]        S_AXIL_RRESP;
  logic              S_AXIL_RVALID;
  logic              S_AXIL_RREADY = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m   [SLOTS];
  bit          known_m [SLOTS];
  logic [31:0] rd_addr_q[$];
  logic [31:0] rd_data_q[$];
  bit          rd_known_q[$];
  logic [1:0]  rd_resp_q[$];

  axi_lite_banked_memory #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXIL_AWADDR(S_AXIL_AWADDR), .S_AXIL_AWVALID(S_AXIL_AWVALID), .S_AXIL_AWREADY(S_AXIL_AWREADY),
    .S_AXIL_WDATA(S_AXIL_WDATA), .S_AXIL_WSTRB(S_AXIL_WSTRB),
    .S_AXIL_WVALID(S_AXIL_WVALID), .S_AXIL_WREADY(S_AXIL_WREADY),
    .S_AXIL_BRESP(S_AXIL_BRESP), .S_AXIL_BVALID(S_AXIL_BVALID), .S_AXIL_BREADY(S_AXIL_BREADY),
    .S_AXIL_ARADDR(S_AXIL_ARADDR), .S_AXIL_ARVALID(S_AXIL_ARVALID), .S_AXIL_ARREADY(S_AXIL_ARREADY),
    .S_AXIL_RDATA(S_AXIL_RDATA), .S_AXIL_RRESP(S_AXIL_RRESP),
    .S_AXIL_RVALID(S_AXIL_RVALID), .S_AXIL_RREADY(S_AXIL_RREADY)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model: byte address -> word slot, out-of-range words never hold data.
  function automatic bit m_stored(input logic [31:0] addr);
`ifdef AXIL_MEM_ADDR_CHECK_EN
    return (addr >> 2) < DEPTH;
`else
    return ((addr >> 2) % SLOTS) < DEPTH;
`endif
  endfunction

  function automatic int m_slot(input logic [31:0] addr);
    return int'((addr >> 2) % SLOTS);
  endfunction

  function automatic logic [1:0] m_resp(input logic [31:0] addr);
`ifdef AXIL_MEM_ADDR_CHECK_EN
    return ((addr >> 2) < DEPTH) ? 2'b00 : 2'b11;
`else
    return 2'b00;
`endif
  endfunction

  task automatic m_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    if (m_stored(addr)) begin
      int s;
      s = m_slot(addr);
      for (int b = 0; b < 4; b++) if (strb[b]) mem_m[s][8*b +: 8] = data[8*b +: 8];
      if (strb == 4'hF) known_m[s] = 1'b1;
    end
  endtask

  task automatic push_exp(input logic [31:0] addr, input logic [31:0] data, input bit known, input logic [1:0] resp);
    rd_addr_q.push_back(addr);
    rd_data_q.push_back(data);
    rd_known_q.push_back(known);
    rd_resp_q.push_back(resp);
  endtask

  task automatic queue_read(input logic [31:0] addr);
    if (m_stored(addr)) push_exp(addr, mem_m[m_slot(addr)], known_m[m_slot(addr)], m_resp(addr));
    else                push_exp(addr, 32'h0, 1'b1, m_resp(addr));
  endtask

  task automatic drive_aw(input logic [31:0] addr, input int dly);
    bit hs;
    hs = 1'b0;
    repeat (dly) begin @(posedge ACLK); #1; end
    S_AXIL_AWADDR = addr;
    S_AXIL_AWVALID = 1'b1;
    for (int t = 0; t < 50 && !hs; t++) begin
      @(negedge ACLK); hs = S_AXIL_AWREADY;
      @(posedge ACLK); #1;
    end
    S_AXIL_AWVALID = 1'b0;
    checks++;
    if (!hs) begin errors++; $display("[TB] FAIL aw_handshake addr=%h got=no_accept exp=accept", addr); end
  endtask

  task automatic drive_w(input logic [31:0] data, input logic [3:0] strb, input int dly);
    bit hs;
    hs = 1'b0;
    repeat (dly) begin @(posedge ACLK); #1; end
    S_AXIL_WDATA = data;
    S_AXIL_WSTRB = strb;
    S_AXIL_WVALID = 1'b1;
    for (int t = 0; t < 50 && !hs; t++) begin
      @(negedge ACLK); hs = S_AXIL_WREADY;
      @(posedge ACLK); #1;
    end
    S_AXIL_WVALID = 1'b0;
    checks++;
    if (!hs) begin errors++; $display("[TB] FAIL w_handshake data=%h got=no_accept exp=accept", data); end
  endtask

  // Called one step after the last of AW/W was captured; B must rise on the very next edge.
  task automatic finish_b(input logic [1:0] exp_resp, input int hold);
    checks++;
    if (S_AXIL_BVALID !== 1'b0) begin errors++; $display("[TB] FAIL b_early got=%b exp=0", S_AXIL_BVALID); end
    @(posedge ACLK); #1;
    checks++;
    if (S_AXIL_BVALID !== 1'b1) begin
      errors++; $display("[TB] FAIL b_latency got=%b exp=1", S_AXIL_BVALID);
      for (int t = 0; t < 20 && S_AXIL_BVALID !== 1'b1; t++) begin @(posedge ACLK); #1; end
    end
    checks++;
    if ({S_AXIL_AWREADY, S_AXIL_WREADY} !== 2'b11) begin
      errors++; $display("[TB] FAIL ready_restore got=%b exp=11", {S_AXIL_AWREADY, S_AXIL_WREADY});
    end
    for (int h = 0; h <= hold; h++) begin
      checks++;
      if ({S_AXIL_BVALID, S_AXIL_BRESP} !== {1'b1, exp_resp}) begin
        errors++; $display("[TB] FAIL b_hold cyc=%0d got=%b/%b exp=1/%b", h, S_AXIL_BVALID, S_AXIL_BRESP, exp_resp);
      end
      if (h < hold) begin @(posedge ACLK); #1; end
    end
    S_AXIL_BREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXIL_BREADY = 1'b0;
    checks++;
    if (S_AXIL_BVALID !== 1'b0) begin errors++; $display("[TB] FAIL b_clear got=%b exp=0", S_AXIL_BVALID); end
  endtask

  task automatic write_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int awd, input int wd, input int hold);
    fork
      drive_aw(addr, awd);
      drive_w(data, strb, wd);
    join
    m_write(addr, data, strb);
    finish_b(m_resp(addr), hold);
  endtask

  // Issues every queued read back-to-back with RREADY high; data must follow each AR by one edge.
  task automatic read_burst();
    int n;
    n = rd_addr_q.size();
    S_AXIL_RREADY = 1'b1;
    for (int k = 0; k <= n; k++) begin
      if (k > 0) begin
        checks++;
        if ({S_AXIL_RVALID, S_AXIL_RRESP} !== {1'b1, rd_resp_q[k-1]}) begin
          errors++; $display("[TB] FAIL r_valid_resp addr=%h got=%b/%b exp=1/%b", rd_addr_q[k-1], S_AXIL_RVALID, S_AXIL_RRESP, rd_resp_q[k-1]);
        end
        if (rd_known_q[k-1]) begin
          checks++;
          if (S_AXIL_RDATA !== rd_data_q[k-1]) begin
            errors++; $display("[TB] FAIL rdata addr=%h got=%h exp=%h", rd_addr_q[k-1], S_AXIL_RDATA, rd_data_q[k-1]);
          end
        end
      end
      if (k < n) begin
        S_AXIL_ARADDR = rd_addr_q[k];
        S_AXIL_ARVALID = 1'b1;
      end else begin
        S_AXIL_ARVALID = 1'b0;
      end
      @(negedge ACLK);
      if (k < n) begin
        checks++;
        if (S_AXIL_ARREADY !== 1'b1) begin errors++; $display("[TB] FAIL arready_burst k=%0d got=%b exp=1", k, S_AXIL_ARREADY); end
      end
      @(posedge ACLK); #1;
    end
    rd_addr_q.delete(); rd_data_q.delete(); rd_known_q.delete(); rd_resp_q.delete();
  endtask

  task automatic test_reset();
    S_AXIL_RREADY = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    checks++;
    if ({S_AXIL_AWREADY, S_AXIL_WREADY, S_AXIL_BVALID, S_AXIL_BRESP, S_AXIL_ARREADY,
         S_AXIL_RVALID, S_AXIL_RDATA, S_AXIL_RRESP} !== 41'h0) begin
      errors++; $display("[TB] FAIL reset_values got=aw%b w%b b%b/%b ar%b r%b/%h/%b exp=all zero",
        S_AXIL_AWREADY, S_AXIL_WREADY, S_AXIL_BVALID, S_AXIL_BRESP, S_AXIL_ARREADY, S_AXIL_RVALID, S_AXIL_RDATA, S_AXIL_RRESP);
    end
    ARESET = 1'b0;
    #1;
    checks++;
    if (S_AXIL_ARREADY !== 1'b1) begin errors++; $display("[TB] FAIL arready_after_reset got=%b exp=1", S_AXIL_ARREADY); end
    @(posedge ACLK); #1;
    checks++;
    if ({S_AXIL_AWREADY, S_AXIL_WREADY, S_AXIL_BVALID, S_AXIL_RVALID} !== 4'b1100) begin
      errors++; $display("[TB] FAIL ready_after_reset got=%b exp=1100", {S_AXIL_AWREADY, S_AXIL_WREADY, S_AXIL_BVALID, S_AXIL_RVALID});
    end
  endtask

  task automatic test_burst_write();
    for (int i = 0; i < 40; i++) write_txn(32'(4*i), 32'hAB00CD00 | 32'(i), 4'hF, 0, 0, 3);
    for (int i = 0; i < 40; i++) queue_read(32'(4*i));
    read_burst();
  endtask

  task automatic test_w_before_aw();
    fork
      drive_aw(32'h10, 4);
      begin
        drive_w(32'h11223344, 4'hF, 0);
        checks++;
        if ({S_AXIL_WREADY, S_AXIL_BVALID} !== 2'b00) begin
          errors++; $display("[TB] FAIL w_held got=wready%b bvalid%b exp=00", S_AXIL_WREADY, S_AXIL_BVALID);
        end
      end
    join
    m_write(32'h10, 32'h11223344, 4'hF);
    finish_b(2'b00, 0);
    push_exp(32'h10, 32'h11223344, 1'b1, 2'b00);
    read_burst();
  endtask

  task automatic test_strobe();
    write_txn(32'h20, 32'hFFFFFFFF, 4'hF, $urandom_range(0, 2), $urandom_range(0, 2), 0);
    write_txn(32'h20, 32'h00000000, 4'b0101, $urandom_range(0, 2), $urandom_range(0, 2), 1);
    write_txn(32'h20, $urandom, 4'b0000, 0, 0, 0);
    push_exp(32'h20, 32'hFF00FF00, 1'b1, 2'b00);
    read_burst();
  endtask

  task automatic test_out_of_range();
    write_txn(32'(4*DEPTH), $urandom, 4'hF, 0, 1, 0);
    write_txn(32'(4*(SLOTS+1)), $urandom, 4'hF, 1, 0, 0);
    write_txn(32'(4*(DEPTH-1)) + 32'd3, $urandom, 4'hF, 0, 0, 0);
    queue_read(32'(4*DEPTH));
    queue_read(32'h0);
    queue_read(32'(4*(DEPTH-1)));
    queue_read(32'(4*(SLOTS+1)));
    queue_read(32'h4);
    read_burst();
  endtask

  task automatic test_read_during_write();
    logic [31:0] old;
    write_txn(32'd20, 32'h5, 4'hF, 0, 0, 0);
    old = mem_m[5];
    S_AXIL_RREADY = 1'b1;
    S_AXIL_AWADDR = 32'd20; S_AXIL_AWVALID = 1'b1;
    S_AXIL_WDATA = 32'hDEADBEEF; S_AXIL_WSTRB = 4'hF; S_AXIL_WVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AXIL_AWVALID = 1'b0; S_AXIL_WVALID = 1'b0;
    S_AXIL_ARADDR = 32'd20; S_AXIL_ARVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AXIL_ARVALID = 1'b0;
    checks++;
    if ({S_AXIL_RVALID, S_AXIL_RDATA} !== {1'b1, old}) begin
      errors++; $display("[TB] FAIL rdw_old_data got=%b/%h exp=1/%h", S_AXIL_RVALID, S_AXIL_RDATA, old);
    end
    checks++;
    if (S_AXIL_BVALID !== 1'b1) begin errors++; $display("[TB] FAIL rdw_commit got=%b exp=1", S_AXIL_BVALID); end
    m_write(32'd20, 32'hDEADBEEF, 4'hF);
    S_AXIL_BREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXIL_BREADY = 1'b0;
    queue_read(32'd20);
    read_burst();
  endtask

  task automatic test_read_stall();
    logic [31:0] addr, exp;
    addr = 32'(4 * $urandom_range(0, 39));
    exp = mem_m[m_slot(addr)];
    S_AXIL_RREADY = 1'b0;
    S_AXIL_ARADDR = addr; S_AXIL_ARVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AXIL_ARVALID = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({S_AXIL_RVALID, S_AXIL_RDATA, S_AXIL_ARREADY} !== {1'b1, exp, 1'b0}) begin
        errors++; $display("[TB] FAIL r_stall cyc=%0d got=%b/%h/ar%b exp=1/%h/ar0", c, S_AXIL_RVALID, S_AXIL_RDATA, S_AXIL_ARREADY, exp);
      end
      @(posedge ACLK); #1;
    end
    S_AXIL_RREADY = 1'b1;
    @(posedge ACLK); #1;
    checks++;
    if (S_AXIL_RVALID !== 1'b0) begin errors++; $display("[TB] FAIL r_release got=%b exp=0", S_AXIL_RVALID); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      int w;
      w = ($urandom_range(0, 4) == 0) ? $urandom_range(DEPTH, SLOTS + 10) : $urandom_range(0, DEPTH - 1);
      write_txn(32'(4*w) + 32'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end
    for (int i = 0; i < 25; i++) queue_read(32'(4 * $urandom_range(0, SLOTS + 10)) + 32'($urandom_range(0, 3)));
    read_burst();
  endtask

  task automatic test_reset_mid();
    logic [31:0] d1, d2;
    d1 = $urandom; d2 = $urandom;
    fork
      drive_aw(32'd200, 0);
      drive_w(d1, 4'hF, 0);
    join
    m_write(32'd200, d1, 4'hF);
    @(posedge ACLK); #1;
    S_AXIL_RREADY = 1'b0;
    S_AXIL_AWADDR = 32'd244; S_AXIL_AWVALID = 1'b1;
    S_AXIL_ARADDR = 32'd200; S_AXIL_ARVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AXIL_AWVALID = 1'b0; S_AXIL_ARVALID = 1'b0;
    checks++;
    if ({S_AXIL_BVALID, S_AXIL_AWREADY, S_AXIL_RVALID} !== 3'b101) begin
      errors++; $display("[TB] FAIL pre_reset_state got=%b exp=101", {S_AXIL_BVALID, S_AXIL_AWREADY, S_AXIL_RVALID});
    end
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    checks++;
    if ({S_AXIL_AWREADY, S_AXIL_WREADY, S_AXIL_BVALID, S_AXIL_BRESP, S_AXIL_ARREADY,
         S_AXIL_RVALID, S_AXIL_RDATA, S_AXIL_RRESP} !== 41'h0) begin
      errors++; $display("[TB] FAIL mid_reset_values got=aw%b w%b b%b/%b ar%b r%b/%h/%b exp=all zero",
        S_AXIL_AWREADY, S_AXIL_WREADY, S_AXIL_BVALID, S_AXIL_BRESP, S_AXIL_ARREADY, S_AXIL_RVALID, S_AXIL_RDATA, S_AXIL_RRESP);
    end
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    checks++;
    if ({S_AXIL_AWREADY, S_AXIL_WREADY, S_AXIL_BVALID, S_AXIL_RVALID} !== 4'b1100) begin
      errors++; $display("[TB] FAIL post_reset got=%b exp=1100", {S_AXIL_AWREADY, S_AXIL_WREADY, S_AXIL_BVALID, S_AXIL_RVALID});
    end
    drive_w(d2, 4'hF, 0);
    repeat (2) begin @(posedge ACLK); #1; end
    checks++;
    if (S_AXIL_BVALID !== 1'b0) begin errors++; $display("[TB] FAIL held_aw_discarded got=%b exp=0", S_AXIL_BVALID); end
    drive_aw(32'd240, 0);
    m_write(32'd240, d2, 4'hF);
    finish_b(m_resp(32'd240), 0);
    queue_read(32'd200);
    queue_read(32'd240);
    queue_read(32'd244);
    read_burst();
  endtask

  initial begin
    for (int i = 0; i < SLOTS; i++) known_m[i] = 1'b0;
    test_reset();
    test_burst_write();
    test_w_before_aw();
    test_strobe();
    test_out_of_range();
    test_read_during_write();
    test_read_stall();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
